// File: rtl/dsm_interp_feeder.sv
// Linear-interpolating feeder for the delta-sigma DAC modulator. It takes low-rate signed PCM
// over valid/ready and ramps between consecutive samples, producing one sample per clock.
module dsm_interp_feeder #(
  parameter int BW       = 16,
  parameter int OSR_LOG2 = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic signed [BW-1:0] in_data_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic signed [BW-1:0] dac_data_o,
  output logic                 active_o,
  output logic                 underrun_o
);

  localparam int AW = BW + OSR_LOG2;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_FILL,
    S_RUN
  } state_t;

  state_t                 r_state;
  logic signed [BW-1:0]   r_pend;
  logic                   r_pend_valid;
  logic signed [BW-1:0]   r_cur;
  logic signed [BW-1:0]   r_nxt;
  logic signed [BW:0]     r_delta;
  logic signed [AW-1:0]   r_acc;
  logic [OSR_LOG2-1:0]    r_phase;
  logic                   r_active;
  logic                   r_underrun;

  logic                   w_accept;
  logic                   w_last;
  logic signed [AW-1:0]   w_pend_shl;
  logic signed [AW-1:0]   w_nxt_shl;
  logic signed [AW-1:0]   w_delta_ext;
  logic signed [BW:0]     w_pend_ext;
  logic signed [BW:0]     w_cur_ext;
  logic signed [BW:0]     w_nxt_ext;

  // The ready signal depends only on buffer occupancy and reset, never on in_valid_i.
  assign in_ready_o  = ~r_pend_valid & ~rst_i;
  assign w_accept    = in_valid_i & in_ready_o;
  assign w_last      = &r_phase;

  assign w_pend_shl  = {r_pend, {OSR_LOG2{1'b0}}};
  assign w_nxt_shl   = {r_nxt, {OSR_LOG2{1'b0}}};
  assign w_pend_ext  = {r_pend[BW-1], r_pend};
  assign w_cur_ext   = {r_cur[BW-1], r_cur};
  assign w_nxt_ext   = {r_nxt[BW-1], r_nxt};
  assign w_delta_ext = AW'(r_delta);

  // The upper slice of the accumulator is a floor divide by the interpolation ratio.
  assign dac_data_o  = r_acc[AW-1:OSR_LOG2];
  assign active_o    = r_active;
  assign underrun_o  = r_underrun;

  // NOTE: all state is updated with non-blocking assignments, so every branch below reads the
  // values from before this edge. That is why a sample accepted at a segment boundary is not
  // consumed at that same boundary.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_EMPTY;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_cur        <= '0;
      r_nxt        <= '0;
      r_delta      <= '0;
      r_acc        <= '0;
      r_phase      <= '0;
      r_active     <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_underrun <= 1'b0;

      case (r_state)
        S_EMPTY: begin
          r_acc <= '0;
          if (r_pend_valid) begin
            r_cur        <= r_pend;
            r_acc        <= w_pend_shl;
            r_pend_valid <= 1'b0;
            r_state      <= S_FILL;
          end
        end

        S_FILL: begin
          // The accumulator already holds cur, so the first RUN cycle outputs cur.
          if (r_pend_valid) begin
            r_nxt        <= r_pend;
            r_delta      <= w_pend_ext - w_cur_ext;
            r_phase      <= '0;
            r_pend_valid <= 1'b0;
            r_active     <= 1'b1;
            r_state      <= S_RUN;
          end
        end

        S_RUN: begin
          if (!w_last) begin
            r_acc   <= r_acc + w_delta_ext;
            r_phase <= r_phase + 1'b1;
          end else begin
            r_acc   <= w_nxt_shl;
            r_cur   <= r_nxt;
            r_phase <= '0;
            if (r_pend_valid) begin
              r_nxt        <= r_pend;
              r_delta      <= w_pend_ext - w_nxt_ext;
              r_pend_valid <= 1'b0;
            end else begin
              // Starved: hold the last endpoint flat for a whole segment.
              r_delta    <= '0;
              r_underrun <= 1'b1;
            end
          end
        end

        default: r_state <= S_EMPTY;
      endcase

      // A sample can only be accepted while the buffer is empty, so it never collides
      // with a consume in the same cycle.
      if (w_accept) begin
        r_pend       <= in_data_i;
        r_pend_valid <= 1'b1;
      end
    end
  end

endmodule
